// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (port 1 wins),
// post-reset scrub engine. Optional same-cycle write-to-read forwarding via REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned ZERO_REG0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [$clog2(DEPTH)-1:0] wa0,
  input  logic [DW-1:0]         wd0,
  input  logic                  we1,
  input  logic [$clog2(DEPTH)-1:0] wa1,
  input  logic [DW-1:0]         wd1,
  input  logic [NRD*$clog2(DEPTH)-1:0] ra,
  output logic [NRD*DW-1:0]     rd,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam bit Zero = (ZERO_REG0 != 0);
  // Entry 0 never needs scrubbing when it is hardwired to zero.
  localparam logic [AW:0] ScFirst = Zero ? (AW+1)'(1) : (AW+1)'(0);
  localparam logic [AW:0] ScLast  = (AW+1)'(DEPTH - 1);

  typedef enum logic [0:0] {StScrub, StRun} state_e;

  state_e      state_q, state_d;
  logic [AW:0] sc_q, sc_d;
  logic        scrub_we;
  logic        run;
  logic        wr0_en, wr1_en;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StScrub;
      sc_q    <= ScFirst;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    unique case (state_q)
      StScrub: begin
        if (sc_q == ScLast) begin
          state_d = StRun;
        end else begin
          sc_d = sc_q + (AW+1)'(1);
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StScrub;
        sc_d    = ScFirst;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == StScrub);
    scrub_we = (state_q == StScrub);
    run      = (state_q == StRun);
  end

  // Dropped writes (busy, or entry 0 when hardwired) are masked here so they are never forwarded.
  assign wr0_en = run && we0 && !(Zero && (wa0 == '0));
  assign wr1_en = run && we1 && !(Zero && (wa1 == '0));

  // Storage is deliberately not reset; the scrub engine clears it instead.
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[sc_q[AW-1:0]] <= '0;
    end else begin
      if (wr0_en) begin
        mem[wa0] <= wd0;
      end
      if (wr1_en) begin
        mem[wa1] <= wd1;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    assign addr = ra[g*AW +: AW];

    always_comb begin
      data = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr1_en && (wa1 == addr)) begin
        data = wd1;
      end else if (wr0_en && (wa0 == addr)) begin
        data = wd0;
      end
`endif
      if (busy || (Zero && (addr == '0))) begin
        data = '0;
      end
    end

    assign rd[g*DW +: DW] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based reference model;
// forwarding expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic              clk;
  logic              rst;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic              busy;

  regfile_mp #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .ZERO_REG0(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .we0 (we0),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra  (ra),
    .rd  (rd),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: entry contents plus number of scrub edges still to come.
  logic [DW-1:0] model [DEPTH];
  int            remaining;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst || remaining > 0) return '0;
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return model[a];
  endfunction

  // Check outputs for the current inputs, then advance one clock edge and the model.
  task automatic cycle();
    #3;
    check("busy", DW'(busy), DW'(rst || remaining > 0));
    for (int i = 0; i < int'(NRD); i++) begin
      check($sformatf("rd%0d", i), rd[i*DW +: DW], exp_rd(ra[i*AW +: AW]));
    end
    @(posedge clk);
    if (rst) begin
      remaining = DEPTH - 1;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        for (int k = 0; k < int'(DEPTH); k++) model[k] = '0;
      end
    end else begin
      if (we0 && wa0 != '0) model[wa0] = wd0;
      if (we1 && wa1 != '0) model[wa1] = wd1;
    end
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0;   wa1 = '0;
    wd0 = '0;   wd1 = '0;
  endtask

  int nb;

  initial begin
    rst = 1'b1;
    remaining = DEPTH - 1;
    idle();
    ra = '0;
    for (int k = 0; k < int'(DEPTH); k++) model[k] = '0;

    @(posedge clk); #1;
    check("reset_busy", DW'(busy), DW'(1));
    cycle();
    cycle();
    rst = 1'b0;

    count_busy(nb);
    check("busy_len", DW'(nb), DW'(31));
    ra = {5'd31, 5'd1};
    #2;
    check("scrub_rd0", rd[0 +: DW], 32'h0);
    check("scrub_rd1", rd[DW +: DW], 32'h0);
    cycle();

    // Restart, then reset again mid-scrub once entry 12 is next.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
    count_busy(nb);
    check("restart_busy_len", DW'(nb), DW'(31));
    idle();
    ra = {5'd1, 5'd3};
    #2;
    check("busy_write_dropped", rd[0 +: DW], 32'h0);
    cycle();

    // Plain write then read.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678;
    cycle();
    idle();
    ra = {5'd0, 5'd5};
    #2;
    check("write5", rd[0 +: DW], 32'h12345678);
    cycle();

    // Write to hardwired entry 0.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    cycle();
    idle();
    ra = {5'd5, 5'd0};
    #2;
    check("zero_reg", rd[0 +: DW], 32'h0);
    cycle();

    // Same-address collision: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000BBBB;
    cycle();
    idle();
    ra = {5'd0, 5'd7};
    #2;
    check("collision", rd[0 +: DW], 32'h0000BBBB);
    cycle();

    // Same-cycle forwarding on lane 1.
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hDEADBEEF;
    ra = {5'd9, 5'd0};
    #2;
`ifdef REGFILE_BYPASS_EN
    check("forward", rd[DW +: DW], 32'hDEADBEEF);
`else
    check("forward", rd[DW +: DW], 32'h0);
`endif
    cycle();
    idle();
    ra = {5'd9, 5'd9};
    #2;
    check("after_fwd", rd[DW +: DW], 32'hDEADBEEF);
    cycle();

    // Random traffic with dense address collisions.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = 5'($urandom_range(0, 9));
      wa1 = 5'($urandom_range(0, 9));
      wd0 = $urandom;
      wd1 = $urandom;
      ra  = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      if (i % 97 == 50) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end

    idle();
    count_busy(nb);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
